issue_scoreboard: RTL and testbench
===================================

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 Parameter MAX_LONG, default 4, maximum number of outstanding long-latency (load/mul/div) writes.
REQ-002 Parameter FLUSH_CYCLES, default 2, number of cycles the decode slot is killed after a redirect.
REQ-003 clk  in  1  core clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-005 id_valid  in  1  decode stage holds a valid decoded instruction.
REQ-006 id_rs1, id_rs2  in  5 each  source register indices.
REQ-007 id_rs1_used, id_rs2_used  in  1 each  the instruction reads that source.
REQ-008 id_rd  in  5  destination register index.
REQ-009 id_rd_we  in  1  the instruction writes id_rd.
REQ-010 id_long  in  1  the instruction is a long-latency operation.
REQ-011 ex_ready  in  1  execute stage accepts an instruction this cycle.
REQ-012 wb_valid, wb_long  in  1 each  writeback of a long-latency result this cycle.
REQ-013 wb_rd  in  5  writeback destination index.
REQ-014 redirect  in  1  branch/jump redirect resolved in execute.
REQ-015 issue  out  1  instruction moves from decode to execute this cycle.
REQ-016 stall  out  1  decode holds its instruction.
REQ-017 flush_id  out  1  fetch/decode contents are killed.
REQ-018 pending  out  32  per-register outstanding long-write bitmap.
REQ-019 long_count  out  $clog2(MAX_LONG+1)  number of outstanding long writes.

Function
REQ-020 Hazard = (id_rs1_used & rs1!=0 & pending[rs1]) | (id_rs2_used & rs2!=0 & pending[rs2]) | (id_rd_we & rd!=0 & pending[rd]) | (id_long & long_count==MAX_LONG).
REQ-021 issue = id_valid & ex_ready & ~hazard & ~redirect & ~flush_active; combinational, zero latency.
REQ-022 stall = id_valid & ~issue & ~flush_id.
REQ-023 On issue with id_long & id_rd_we & id_rd!=0: pending[id_rd] set and long_count incremented at the next edge.
REQ-024 On wb_valid & wb_long: pending[wb_rd] cleared and long_count decremented at the next edge; no same-cycle bypass into the hazard check.
REQ-025 Simultaneous increment and decrement leaves long_count unchanged; simultaneous set/clear of the same bit resolves as set.
REQ-026 Writeback to a non-pending register or with long_count==0 is ignored (no underflow) and raises no error.
REQ-027 Register x0 is never marked pending.
REQ-028 Flush FSM states IDLE and KILL; redirect in any state loads the kill counter with FLUSH_CYCLES and enters KILL.
REQ-029 flush_id = redirect | (state==KILL); flush_active = state==KILL.
REQ-030 KILL decrements the counter each cycle and returns to IDLE after FLUSH_CYCLES cycles; a new redirect during KILL restarts the count.
REQ-031 The flush does not clear pending bits; writes already issued still complete.

Reset
REQ-032 While rst_n is low: pending=0, long_count=0, state=IDLE, kill counter=0, flush_id=0; issue and stall are 0 by combinational dependence on cleared state and on id_valid.
REQ-033 Reset mid-operation discards all outstanding tracking; later writebacks are ignored per REQ-026.

Structure
REQ-034 The register-index typedef (5-bit), the register count (32) and the default MAX_LONG/FLUSH_CYCLES constants are in the shared core package.
REQ-035 No sub-module; the bitmap, counter and flush FSM are in one module.

Verification
REQ-036 Load x5 issues, next id reads x5 -> stall=1 until the cycle after wb_valid/wb_long/wb_rd=5, then issue=1; pending[5] 1->0.
REQ-037 Issue four long ops (x1..x4, MAX_LONG=4), fifth long op to x6 -> stall=1, long_count=4; one writeback -> fifth issues next cycle.
REQ-038 redirect pulse with id_valid=1 -> issue=0 and flush_id=1 for 1+FLUSH_CYCLES cycles (3 with default); second redirect mid-KILL extends the window.
REQ-039 Same-cycle long issue to x7 and writeback of x3 -> long_count unchanged; pending[7]=1, pending[3]=0.
REQ-040 Long op with rd=x0, and reads of x0 -> no pending bit set, no stall; spurious wb to x9 -> no change.
REQ-041 rst_n low mid-sequence with bits pending -> pending=0, long_count=0, flush_id=0 immediately (asynchronously).

Source files
------------

// File: rtl/issue_scoreboard_pkg.sv
// Shared core definitions for the issue scoreboard: register indexing,
// default sizing constants and the decode-kill FSM state type.
package issue_scoreboard_pkg;

  localparam int unsigned NUM_REGS         = 32;
  localparam int unsigned DEF_MAX_LONG     = 4;
  localparam int unsigned DEF_FLUSH_CYCLES = 2;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic {
    FL_IDLE = 1'b0,
    FL_KILL = 1'b1
  } flush_state_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_idx_t idx);
    logic [NUM_REGS-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Decode-stage issue scoreboard: tracks outstanding long-latency writes per
// register, gates issue on RAW/WAW/capacity hazards and kills decode on redirect.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int unsigned MAX_LONG     = DEF_MAX_LONG,
  parameter int unsigned FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           id_valid,
  input  logic [4:0]                     id_rs1,
  input  logic [4:0]                     id_rs2,
  input  logic                           id_rs1_used,
  input  logic                           id_rs2_used,
  input  logic [4:0]                     id_rd,
  input  logic                           id_rd_we,
  input  logic                           id_long,
  input  logic                           ex_ready,
  input  logic                           wb_valid,
  input  logic                           wb_long,
  input  logic [4:0]                     wb_rd,
  input  logic                           redirect,
  output logic                           issue,
  output logic                           stall,
  output logic                           flush_id,
  output logic [NUM_REGS-1:0]            pending,
  output logic [$clog2(MAX_LONG+1)-1:0]  long_count
);

  localparam int unsigned CW = $clog2(MAX_LONG + 1);
  localparam int unsigned KW = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] MAX_L     = CW'(MAX_LONG);
  localparam logic [KW-1:0] KILL_INIT = KW'(FLUSH_CYCLES);

  logic [NUM_REGS-1:0] r_pending;
  logic [CW-1:0]       r_long_count;
  flush_state_t        r_state;
  logic [KW-1:0]       r_kill_cnt;

  logic [NUM_REGS-1:0] w_pending_nxt;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;
  logic [CW-1:0]       w_count_nxt;
  flush_state_t        w_state_nxt;
  logic [KW-1:0]       w_kill_nxt;
  logic                w_hazard;
  logic                w_flush_active;
  logic                w_issue;
  logic                w_inc;
  logic                w_dec;

  always_comb begin
    w_hazard = 1'b0;
    if (id_rs1_used && (id_rs1 != '0) && r_pending[id_rs1]) w_hazard = 1'b1;
    if (id_rs2_used && (id_rs2 != '0) && r_pending[id_rs2]) w_hazard = 1'b1;
    if (id_rd_we    && (id_rd  != '0) && r_pending[id_rd])  w_hazard = 1'b1;
    if (id_long     && (r_long_count == MAX_L))             w_hazard = 1'b1;
  end

  assign w_flush_active = (r_state == FL_KILL);
  assign w_issue        = id_valid & ex_ready & ~w_hazard & ~redirect & ~w_flush_active;

  // Writebacks only count against a bit that is actually pending, so stale
  // writebacks after a reset can never underflow the counter.
  assign w_inc = w_issue & id_long & id_rd_we & (id_rd != '0);
  assign w_dec = wb_valid & wb_long & r_pending[wb_rd] & (r_long_count != '0);

  always_comb begin
    w_set_mask    = w_inc ? reg_onehot(id_rd) : '0;
    w_clr_mask    = w_dec ? reg_onehot(wb_rd) : '0;
    w_pending_nxt = (r_pending & ~w_clr_mask) | w_set_mask;
    w_pending_nxt[0] = 1'b0;
  end

  always_comb begin
    w_count_nxt = r_long_count;
    if (w_inc && !w_dec)      w_count_nxt = r_long_count + CW'(1);
    else if (!w_inc && w_dec) w_count_nxt = r_long_count - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending    <= '0;
      r_long_count <= '0;
    end else begin
      r_pending    <= w_pending_nxt;
      r_long_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_kill_nxt  = r_kill_cnt;
    case (r_state)
      FL_IDLE: ;
      FL_KILL: begin
        if (r_kill_cnt <= KW'(1)) begin
          w_state_nxt = FL_IDLE;
          w_kill_nxt  = '0;
        end else begin
          w_kill_nxt  = r_kill_cnt - KW'(1);
        end
      end
      default: begin
        w_state_nxt = FL_IDLE;
        w_kill_nxt  = '0;
      end
    endcase
    // A redirect always restarts the kill window, even mid-KILL.
    if (redirect) begin
      if (FLUSH_CYCLES != 0) begin
        w_state_nxt = FL_KILL;
        w_kill_nxt  = KILL_INIT;
      end else begin
        w_state_nxt = FL_IDLE;
        w_kill_nxt  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FL_IDLE;
      r_kill_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_kill_cnt <= w_kill_nxt;
    end
  end

  assign issue      = w_issue;
  assign flush_id   = rst_n & (redirect | w_flush_active);
  assign stall      = id_valid & ~w_issue & ~flush_id;
  assign pending    = r_pending;
  assign long_count = r_long_count;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed self-checking bench for issue_scoreboard with hand-computed expectations.
module tb_issue_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  id_rd;
  logic        id_rd_we;
  logic        id_long;
  logic        ex_ready;
  logic        wb_valid;
  logic        wb_long;
  logic [4:0]  wb_rd;
  logic        redirect;
  logic        issue;
  logic        stall;
  logic        flush_id;
  logic [31:0] pending;
  logic [2:0]  long_count;

  int unsigned n_vec;
  int unsigned n_err;

  issue_scoreboard #(
    .MAX_LONG     (4),
    .FLUSH_CYCLES (2)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_rd_we    (id_rd_we),
    .id_long     (id_long),
    .ex_ready    (ex_ready),
    .wb_valid    (wb_valid),
    .wb_long     (wb_long),
    .wb_rd       (wb_rd),
    .redirect    (redirect),
    .issue       (issue),
    .stall       (stall),
    .flush_id    (flush_id),
    .pending     (pending),
    .long_count  (long_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2, input logic [4:0] rd, input logic we, input logic lng);
    id_valid    = 1'b1;
    id_rs1      = rs1;
    id_rs1_used = u1;
    id_rs2      = rs2;
    id_rs2_used = u2;
    id_rd       = rd;
    id_rd_we    = we;
    id_long     = lng;
  endtask

  task automatic id_off();
    id_valid = 1'b0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    id_rd_we = 1'b0; id_long = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;
  endtask

  task automatic wb_set(input logic [4:0] rd);
    wb_valid = 1'b1;
    wb_long  = 1'b1;
    wb_rd    = rd;
  endtask

  task automatic wb_off();
    wb_valid = 1'b0;
    wb_long  = 1'b0;
    wb_rd    = '0;
  endtask

  initial begin
    logic [4:0] drain [4];
    n_vec = 0;
    n_err = 0;
    rst_n    = 1'b0;
    ex_ready = 1'b0;
    redirect = 1'b0;
    id_off();
    wb_off();

    #3;
    chk("rst_pending", pending, 32'h0);
    chk("rst_count", 32'(long_count), 32'd0);
    chk("rst_flush", 32'(flush_id), 32'd0);
    chk("rst_issue", 32'(issue), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    tick();
    tick();
    rst_n    = 1'b1;
    ex_ready = 1'b1;

    // Load-use on x5
    id_set(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    #2 chk("lu_issue_load", 32'(issue), 32'd1);
    tick();
    id_set(5'd5, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    #2;
    chk("lu_stall", 32'(stall), 32'd1);
    chk("lu_no_issue", 32'(issue), 32'd0);
    chk("lu_pending", pending, 32'h0000_0020);
    chk("lu_count", 32'(long_count), 32'd1);
    tick();
    #2 chk("lu_stall2", 32'(stall), 32'd1);
    wb_set(5'd5);
    #2 chk("lu_no_bypass", 32'(issue), 32'd0);
    tick();
    wb_off();
    #2;
    chk("lu_pending_clr", pending, 32'h0);
    chk("lu_issue_after", 32'(issue), 32'd1);
    chk("lu_stall_after", 32'(stall), 32'd0);
    tick();
    id_off();

    // Capacity limit
    for (int i = 1; i <= 4; i++) begin
      id_set(5'd0, 1'b0, 5'd0, 1'b0, 5'(i), 1'b1, 1'b1);
      #2 chk("cap_issue", 32'(issue), 32'd1);
      tick();
    end
    id_set(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
    #2;
    chk("cap_stall", 32'(stall), 32'd1);
    chk("cap_count4", 32'(long_count), 32'd4);
    chk("cap_pending", pending, 32'h0000_001E);
    wb_set(5'd2);
    #2 chk("cap_wb_no_bypass", 32'(issue), 32'd0);
    tick();
    wb_off();
    #2;
    chk("cap_issue5", 32'(issue), 32'd1);
    chk("cap_count3", 32'(long_count), 32'd3);
    chk("cap_pending3", pending, 32'h0000_001A);
    tick();
    id_off();
    #2;
    chk("cap_count_full", 32'(long_count), 32'd4);
    chk("cap_pending_full", pending, 32'h0000_005A);
    drain[0] = 5'd1; drain[1] = 5'd3; drain[2] = 5'd4; drain[3] = 5'd6;
    for (int i = 0; i < 4; i++) begin
      wb_set(drain[i]);
      tick();
    end
    wb_off();
    #2;
    chk("drain_count", 32'(long_count), 32'd0);
    chk("drain_pending", pending, 32'h0);

    // Simultaneous issue and writeback
    id_set(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
    tick();
    id_set(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    wb_set(5'd3);
    #2 chk("sim_issue", 32'(issue), 32'd1);
    tick();
    id_off();
    wb_off();
    #2;
    chk("sim_count", 32'(long_count), 32'd1);
    chk("sim_pending", pending, 32'h0000_0080);
    wb_set(5'd9);
    tick();
    wb_off();
    #2;
    chk("spur_count", 32'(long_count), 32'd1);
    chk("spur_pending", pending, 32'h0000_0080);
    wb_set(5'd7);
    tick();
    wb_off();
    #2 chk("x7_drain", 32'(long_count), 32'd0);

    // x0 handling and underflow protection
    id_set(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1);
    #2;
    chk("x0_issue", 32'(issue), 32'd1);
    chk("x0_stall", 32'(stall), 32'd0);
    tick();
    id_off();
    #2;
    chk("x0_pending", pending, 32'h0);
    chk("x0_count", 32'(long_count), 32'd0);
    wb_set(5'd9);
    tick();
    wb_off();
    #2;
    chk("underflow_count", 32'(long_count), 32'd0);
    chk("underflow_pending", pending, 32'h0);

    // Redirect kill window
    id_set(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    redirect = 1'b1;
    #2;
    chk("rd_issue0", 32'(issue), 32'd0);
    chk("rd_flush0", 32'(flush_id), 32'd1);
    chk("rd_stall0", 32'(stall), 32'd0);
    tick();
    redirect = 1'b0;
    #2;
    chk("rd_flush1", 32'(flush_id), 32'd1);
    chk("rd_issue1", 32'(issue), 32'd0);
    tick();
    #2 chk("rd_flush2", 32'(flush_id), 32'd1);
    tick();
    #2;
    chk("rd_flush3", 32'(flush_id), 32'd0);
    chk("rd_issue3", 32'(issue), 32'd1);

    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    tick();
    redirect = 1'b1;
    #2 chk("ext_flush2", 32'(flush_id), 32'd1);
    tick();
    redirect = 1'b0;
    #2 chk("ext_flush3", 32'(flush_id), 32'd1);
    tick();
    #2 chk("ext_flush4", 32'(flush_id), 32'd1);
    tick();
    #2;
    chk("ext_flush5", 32'(flush_id), 32'd0);
    chk("ext_issue5", 32'(issue), 32'd1);
    tick();

    // Asynchronous reset mid-operation
    id_set(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    id_off();
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    #2;
    chk("ar_flush_pre", 32'(flush_id), 32'd1);
    chk("ar_pending_pre", pending, 32'h0000_0020);
    chk("ar_count_pre", 32'(long_count), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_pending", pending, 32'h0);
    chk("ar_count", 32'(long_count), 32'd0);
    chk("ar_flush", 32'(flush_id), 32'd0);
    tick();
    rst_n = 1'b1;
    wb_set(5'd5);
    tick();
    wb_off();
    #2;
    chk("ar_late_wb_count", 32'(long_count), 32'd0);
    chk("ar_late_wb_pending", pending, 32'h0);
    chk("ar_flush_idle", 32'(flush_id), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
